// File: rtl/inst_sram_if.sv
// Request/response bundle between the IF1 fetch stage (master) and the instruction SRAM (slave).
interface inst_sram_if;
  logic        en;
  logic [7:0]  we;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [63:0] rdata;
  logic        rvalid;
  logic        err;
  logic        stallreq;

  modport master (output en, we, addr, wdata, input rdata, rvalid, err, stallreq);
  modport slave  (input en, we, addr, wdata, output rdata, rvalid, err, stallreq);
endinterface

// File: rtl/inst_sram_resp.sv
// Instruction SRAM responder: 64-bit words, reads answer at accept+WAIT+1, writes are silent.
// Backpressure: stallreq holds the fetch front end for WAIT cycles of each read; en is ignored while waiting.
module inst_sram_resp #(
  parameter int unsigned ADDR_W = 12,
  parameter logic [31:0] BASE   = 32'h8000_0000,
  parameter int unsigned WAIT   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  inst_sram_if.slave        sram,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [63:0]       ld_data
);
  localparam int unsigned DEPTH    = 1 << ADDR_W;
  localparam logic [2:0]  CNT_INIT = (WAIT == 0) ? 3'd0 : 3'(WAIT - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t            state, state_nxt;
  logic [2:0]        cnt, cnt_nxt;
  logic [63:0]       mem [DEPTH];
  logic [ADDR_W-1:0] idx_q;
  logic              err_q;
  logic [63:0]       rdata_q;
  logic              rvalid_q;
  logic              err_r;
  logic              stall_c;

  logic [31:0]       addr32;
  logic [31:0]       off;
  logic [ADDR_W-1:0] idx;
  logic              in_range;
  logic              misaligned;
  logic              req_err;
  logic              is_read;
  logic              accept;
  logic              wr_ok;
  logic              wait_done;
  logic              unused_bits;

  assign addr32      = sram.addr[31:0];
  assign off         = addr32 - BASE;
  assign idx         = off[ADDR_W+2:3];
  assign in_range    = (addr32 >= BASE) && ({1'b0, off >> 3} < (33'd1 << ADDR_W));
  assign misaligned  = addr32[1:0] != 2'b00;
  assign req_err     = !in_range || misaligned;
  assign is_read     = sram.we == 8'h00;
  assign accept      = rst_n && (state == S_IDLE) && sram.en;
  assign wr_ok       = accept && !is_read && !req_err;
  assign wait_done   = (state == S_WAIT) && (cnt == 3'd0);
  assign unused_bits = ^{sram.addr[63:32], off[2:0]};

  // Stall covers the accept cycle plus every WAIT cycle whose counter is still non-zero.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall_c   = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept && is_read && (WAIT != 0)) begin
          state_nxt = S_WAIT;
          cnt_nxt   = CNT_INIT;
          stall_c   = 1'b1;
        end
      end
      S_WAIT: begin
        if (cnt == 3'd0) begin
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt - 3'd1;
          stall_c = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= 3'd0;
      idx_q    <= '0;
      err_q    <= 1'b0;
      rdata_q  <= 64'd0;
      rvalid_q <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      rvalid_q <= 1'b0;
      err_r    <= 1'b0;
      if (accept) begin
        if (is_read) begin
          if (WAIT == 0) begin
            rvalid_q <= 1'b1;
            err_r    <= req_err;
            rdata_q  <= req_err ? 64'd0 : mem[idx];
          end else begin
            idx_q <= idx;
            err_q <= req_err;
          end
        end else if (req_err) begin
          rvalid_q <= 1'b1;
          err_r    <= 1'b1;
          rdata_q  <= 64'd0;
        end
      end
      if (wait_done) begin
        rvalid_q <= 1'b1;
        err_r    <= err_q;
        rdata_q  <= err_q ? 64'd0 : mem[idx_q];
      end
    end
  end

  // Array is never reset; the back-door load is placed last so it wins a same-word collision.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      for (int i = 0; i < 8; i++) begin
        if (sram.we[i]) mem[idx][8*i +: 8] <= sram.wdata[8*i +: 8];
      end
    end
    if (ld_en) mem[ld_addr] <= ld_data;
  end

  assign sram.rdata    = rdata_q;
  assign sram.rvalid   = rvalid_q;
  assign sram.err      = err_r;
  assign sram.stallreq = stall_c && rst_n;
endmodule

// File: tb/tb_inst_sram_resp.sv
// Drives three responders (WAIT = 0, 2, 3) from one request stream and checks them
// against directed vectors and a transaction-level timing/memory model.
module tb_inst_sram_resp;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [7:0]  we;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic        ld_en;
  logic [11:0] ld_addr;
  logic [63:0] ld_data;

  int checks = 0;
  int errors = 0;

  logic [63:0] mm [16];

  always #5 clk = ~clk;

  inst_sram_if b0 ();
  inst_sram_if b2 ();
  inst_sram_if b3 ();

  assign b0.en = en;  assign b0.we = we;  assign b0.addr = addr;  assign b0.wdata = wdata;
  assign b2.en = en;  assign b2.we = we;  assign b2.addr = addr;  assign b2.wdata = wdata;
  assign b3.en = en;  assign b3.we = we;  assign b3.addr = addr;  assign b3.wdata = wdata;

  inst_sram_resp #(.WAIT(0)) dut0 (.clk(clk), .rst_n(rst_n), .sram(b0),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));
  inst_sram_resp #(.WAIT(2)) dut2 (.clk(clk), .rst_n(rst_n), .sram(b2),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));
  inst_sram_resp #(.WAIT(3)) dut3 (.clk(clk), .rst_n(rst_n), .sram(b3),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));

  logic [63:0] rd [3];
  logic        vld [3];
  logic        er [3];
  logic        st [3];
  assign rd[0] = b0.rdata;  assign vld[0] = b0.rvalid;  assign er[0] = b0.err;  assign st[0] = b0.stallreq;
  assign rd[1] = b2.rdata;  assign vld[1] = b2.rvalid;  assign er[1] = b2.err;  assign st[1] = b2.stallreq;
  assign rd[2] = b3.rdata;  assign vld[2] = b3.rvalid;  assign er[2] = b3.err;  assign st[2] = b3.stallreq;

  typedef struct {
    logic        en;
    logic [7:0]  we;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic        vld;
    logic        err;
    logic [63:0] rdata;
  } vec_t;

  vec_t tbl [9];

  function automatic int wt_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic want);
    chk(name, 64'(act), 64'(want));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int w, input logic [63:0] d);
    ld_en   = 1'b1;
    ld_addr = 12'(w);
    ld_data = d;
    tick();
    ld_en   = 1'b0;
  endtask

  task automatic idle(input int n);
    en = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    logic [31:0] a;
    logic [7:0]  w;
    logic [63:0] wd;
    logic        merr, is_rd, resp;
    int          widx, r, lat;

    tbl[0] = '{1'b1, 8'h00, 32'h8000_0000, 64'h0, 1'b1, 1'b0, 64'h0000_0013_0000_0093};
    tbl[1] = '{1'b1, 8'h00, 32'h7fff_fffc, 64'h0, 1'b1, 1'b1, 64'h0};
    tbl[2] = '{1'b1, 8'h00, 32'h8000_0002, 64'h0, 1'b1, 1'b1, 64'h0};
    tbl[3] = '{1'b1, 8'h00, 32'h8000_8000, 64'h0, 1'b1, 1'b1, 64'h0};
    tbl[4] = '{1'b1, 8'h0F, 32'h8000_0018, 64'h1122_3344_5566_7788, 1'b0, 1'b0, 64'h0};
    tbl[5] = '{1'b1, 8'h00, 32'h8000_0018, 64'h0, 1'b1, 1'b0, 64'hFFFF_FFFF_5566_7788};
    tbl[6] = '{1'b1, 8'hFF, 32'h8000_0001, 64'h0, 1'b1, 1'b1, 64'h0};
    tbl[7] = '{1'b1, 8'h00, 32'h8000_0004, 64'h0, 1'b1, 1'b0, 64'h0000_0013_0000_0093};
    tbl[8] = '{1'b0, 8'h00, 32'h7fff_fffc, 64'h0, 1'b0, 1'b0, 64'h0};

    rst_n = 1'b0; en = 1'b0; we = '0; addr = '0; wdata = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (3) tick();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset k%0d rdata", k), rd[k], 64'h0);
      chk_b($sformatf("reset k%0d rvalid", k), vld[k], 1'b0);
      chk_b($sformatf("reset k%0d err", k), er[k], 1'b0);
      chk_b($sformatf("reset k%0d stall", k), st[k], 1'b0);
    end
    tick();
    rst_n = 1'b1;

    // Directed single requests on the zero-wait responder.
    load(0, 64'h0000_0013_0000_0093);
    load(3, 64'hFFFF_FFFF_FFFF_FFFF);
    for (int i = 0; i < 9; i++) begin
      en = tbl[i].en; we = tbl[i].we; wdata = tbl[i].wdata;
      addr = {32'($urandom), tbl[i].addr};
      @(negedge clk);
      chk_b($sformatf("tbl%0d stall", i), st[0], 1'b0);
      tick();
      en = 1'b0;
      @(negedge clk);
      chk_b($sformatf("tbl%0d rvalid", i), vld[0], tbl[i].vld);
      chk_b($sformatf("tbl%0d err", i), er[0], tbl[i].err);
      if (tbl[i].vld) chk($sformatf("tbl%0d rdata", i), rd[0], tbl[i].rdata);
      repeat (4) tick();
    end

    for (int i = 0; i < 16; i++) begin
      mm[i] = {$urandom, $urandom};
      load(i, mm[i]);
    end

    // Back-to-back reads at full rate, zero wait states.
    we = 8'h00;
    for (int j = 0; j < 3; j++) begin
      en = 1'b1;
      addr = {32'h0, BASE + 32'(8 * j)};
      @(negedge clk);
      chk_b($sformatf("b2b%0d stall", j), st[0], 1'b0);
      if (j > 0) begin
        chk_b($sformatf("b2b%0d rvalid", j - 1), vld[0], 1'b1);
        chk($sformatf("b2b%0d rdata", j - 1), rd[0], mm[j - 1]);
      end
      tick();
    end
    en = 1'b0;
    @(negedge clk);
    chk_b("b2b2 rvalid", vld[0], 1'b1);
    chk("b2b2 rdata", rd[0], mm[2]);
    tick();
    idle(6);

    // WAIT=2 read with en held through the wait; only one response expected.
    addr = {32'h0, BASE + 32'h8};
    for (int c = 0; c < 5; c++) begin
      en = (c < 3);
      @(negedge clk);
      chk_b($sformatf("w2 c%0d stall", c), st[1], c < 2);
      chk_b($sformatf("w2 c%0d rvalid", c), vld[1], c == 3);
      if (c == 3) chk("w2 rdata", rd[1], mm[1]);
      if (c == 4) chk("w2 rdata hold", rd[1], mm[1]);
      tick();
    end
    idle(6);

    // WAIT=3 read aborted by reset in the middle of its stall.
    addr = {32'h0, BASE + 32'h10};
    en = 1'b1;
    @(negedge clk);
    chk_b("rst c0 stall", st[2], 1'b1);
    tick();
    en = 1'b0;
    @(negedge clk);
    chk_b("rst c1 stall", st[2], 1'b1);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int c = 3; c < 9; c++) begin
      @(negedge clk);
      chk_b($sformatf("rst c%0d rvalid", c), vld[2], 1'b0);
      chk_b($sformatf("rst c%0d stall", c), st[2], 1'b0);
      tick();
    end
    addr = {32'h0, BASE + 32'h28};
    en = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk_b($sformatf("post c%0d stall", c), st[2], c < 3);
      chk_b($sformatf("post c%0d rvalid", c), vld[2], c == 4);
      if (c == 4) chk("post rdata", rd[2], mm[5]);
      tick();
      en = 1'b0;
    end
    idle(2);

    // Random transactions against the model: one request, then quiet until every responder is done.
    for (int t = 0; t < 150; t++) begin
      r = $urandom_range(0, 9);
      widx = $urandom_range(0, 15);
      case (r)
        0:       a = BASE - 32'($urandom_range(1, 64));
        1:       a = BASE + 32'(8 * widx) + 32'($urandom_range(1, 3));
        2:       a = BASE + 32'h8000 + 32'(8 * widx);
        default: a = BASE + 32'(8 * widx) + 32'(4 * $urandom_range(0, 1));
      endcase
      w  = ($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom_range(1, 255));
      wd = {$urandom, $urandom};
      merr  = (a < BASE) || (((a - BASE) >> 3) >= 32'd4096) || (a % 4 != 0);
      is_rd = (w == 8'h00);
      resp  = is_rd || merr;
      if (!merr) widx = int'((a - BASE) >> 3);
      en = 1'b1; we = w; wdata = wd;
      addr = {32'($urandom), a};
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
          lat = is_rd ? wt_of(k) + 1 : 1;
          chk_b($sformatf("rnd%0d k%0d c%0d stall", t, k, c), st[k], is_rd && (c < wt_of(k)));
          chk_b($sformatf("rnd%0d k%0d c%0d rvalid", t, k, c), vld[k], resp && (c == lat));
          if (resp && c == lat) begin
            chk_b($sformatf("rnd%0d k%0d err", t, k), er[k], merr);
            chk($sformatf("rnd%0d k%0d rdata", t, k), rd[k], merr ? 64'h0 : mm[widx]);
          end
        end
        tick();
        en = 1'b0;
      end
      if (!is_rd && !merr) begin
        for (int b = 0; b < 8; b++) begin
          if (w[b]) mm[widx][8*b +: 8] = wd[8*b +: 8];
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
